// File: rtl/dmem_ctrl_if.sv
// Data-memory bus between the RV32I core / logic analyser and dmem_ctrl.
// Core-side signals are combinationally answered; no handshake.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int SEL_W  = 4
);
    logic              mem_write;
    logic              mem_read;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] memory_address;
    logic [31:0]       write_data;
    logic [SEL_W-1:0]  la_dram_select;
    logic [31:0]       read_data;
    logic              access_fault;
    logic              busy;
    logic [31:0]       la_read_data;

    modport master (
        output mem_write, mem_read, funct3, memory_address, write_data, la_dram_select,
        input  read_data, access_fault, busy, la_read_data
    );

    modport slave (
        input  mem_write, mem_read, funct3, memory_address, write_data, la_dram_select,
        output read_data, access_fault, busy, la_read_data
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-lane data memory for the single-cycle RV32I core with load extension, fault flags,
// a post-reset clear sequencer (DEPTH cycles busy) and a raw read port for the logic analyser.
module dmem_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int SEL_W  = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_ctrl_if.slave bus
);
    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt;
    logic [31:0]       dram [DEPTH];

    logic [SEL_W-1:0]  widx;
    logic [1:0]        bl;
    logic [2:0]        f3;
    logic [ADDR_W-1:0] addr_hi;
    logic              ready, oor, misalign, load_bad, store_bad;
    logic              load_fault, store_fault, store_en;
    logic [31:0]       word, load_val, wdat;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [3:0]        be;

    assign ready   = (state == READY);
    assign widx    = bus.memory_address[SEL_W+1:2];
    assign bl      = bus.memory_address[1:0];
    assign f3      = bus.funct3;
    assign addr_hi = bus.memory_address >> (SEL_W + 2);
    assign oor     = |addr_hi;

    assign misalign  = ((f3[1:0] == 2'b01) && bl[0]) || ((f3[1:0] == 2'b10) && (bl != 2'b00));
    assign load_bad  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    assign store_bad = (f3[2] == 1'b1) || (f3[1:0] == 2'b11);

    assign load_fault  = misalign || oor || load_bad;
    assign store_fault = misalign || oor || store_bad;
    assign store_en    = ready && bus.mem_write && !store_fault;

    assign bus.access_fault = ready && ((bus.mem_read && load_fault) || (bus.mem_write && store_fault));
    assign bus.busy         = !ready;
    assign bus.la_read_data = dram[bus.la_dram_select];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (state == CLEAR) begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == SEL_W'(DEPTH - 1)) begin
                state_nxt = READY;
            end
        end
    end

    // Loads read the pre-edge array, so a same-cycle store is not bypassed.
    always_comb begin
        word   = dram[widx];
        byte_v = 8'h00;
        half_v = bl[1] ? word[31:16] : word[15:0];
        case (bl)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        case (f3)
            3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_val = {{16{half_v[15]}}, half_v};
            3'b010:  load_val = word;
            3'b100:  load_val = {24'h0, byte_v};
            3'b101:  load_val = {16'h0, half_v};
            default: load_val = 32'h0;
        endcase
        bus.read_data = (ready && !load_fault) ? load_val : 32'h0;
    end

    always_comb begin
        be   = 4'b0000;
        wdat = bus.write_data;
        case (f3[1:0])
            2'b00: begin
                be   = 4'b0001 << bl;
                wdat = {4{bus.write_data[7:0]}};
            end
            2'b01: begin
                be   = bl[1] ? 4'b1100 : 4'b0011;
                wdat = {2{bus.write_data[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // No reset on the array: the clear sequencer owns initialisation.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            dram[ptr] <= 32'h0;
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    dram[widx][8*b +: 8] <= wdat[8*b +: 8];
                end
            end
        end
    end
endmodule
